exe_mem_issue: RTL and testbench

- Execute-stage memory-request issuer.
- Sits between the decode stage and the memory stage. It:
  - computes the effective address;
  - detects misaligned accesses;
  - drives the data SRAM-like request channel (req/addr_ok handshake);
  - forwards the instruction to the memory stage, tagged with whether a request was issued.
- It also tracks responses orphaned by an exception flush, so the memory stage can drop stale `data_ok` beats.

---
 rtl/exe_mem_issue.sv | 193 +++++++++++++++++++
 tb/tb_exe_mem_issue.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_issue.sv
// Execute-stage memory-request issuer: effective address, misalignment check,
// data SRAM req/addr_ok handshake, and tracking of responses orphaned by a flush.
module exe_mem_issue #(
  parameter int unsigned PAY_W = 150
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ID_to_EXE_valid,
  output logic               EXE_allow,
  input  logic [PAY_W-1:0]   id_payload,
  input  logic [31:0]        id_base,
  input  logic [31:0]        id_offset,
  input  logic [31:0]        id_st_data,
  input  logic               id_mem_re,
  input  logic               id_mem_we,
  input  logic [1:0]         id_mem_size,
  input  logic               id_exception,
  input  logic               MEM_allow,
  input  logic               MEM_exception,
  input  logic               WB_exception,
  input  logic               MEM_wait_data,
  output logic               EXE_to_MEM_valid,
  output logic [PAY_W+33:0]  EXE_to_MEM_bus,
  output logic               data_sram_req,
  output logic               data_sram_wr,
  output logic [1:0]         data_sram_size,
  output logic [3:0]         data_sram_wstrb,
  output logic [31:0]        data_sram_addr,
  output logic [31:0]        data_sram_wdata,
  input  logic               data_sram_addr_ok,
  input  logic               data_sram_data_ok,
  output logic               data_ok_mask
);

  typedef enum logic [1:0] {StIdle, StWait, StDone, StDrain} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              exe_valid_q;
  logic [PAY_W-1:0]  payload_q;
  logic [31:0]       base_q, offset_q, st_data_q;
  logic              mem_re_q, mem_we_q, exc_q;
  logic [1:0]        size_q;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ex_ale, issue_needed, issue_ok;
  logic        req, go, mem_req, inflight;
  logic        load;

  assign load = ID_to_EXE_valid & EXE_allow;

  // EXE pipeline register: valid flag plus operands captured from decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_valid_q <= 1'b0;
      payload_q   <= '0;
      base_q      <= '0;
      offset_q    <= '0;
      st_data_q   <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      size_q      <= 2'd0;
      exc_q       <= 1'b0;
    end else begin
      if (WB_exception) begin
        exe_valid_q <= 1'b0;
      end else if (EXE_allow) begin
        exe_valid_q <= ID_to_EXE_valid;
      end
      if (load) begin
        payload_q <= id_payload;
        base_q    <= id_base;
        offset_q  <= id_offset;
        st_data_q <= id_st_data;
        mem_re_q  <= id_mem_re;
        mem_we_q  <= id_mem_we;
        size_q    <= id_mem_size;
        exc_q     <= id_exception;
      end
    end
  end

  // Effective address, alignment check and store lane shaping
  always_comb begin
    addr   = base_q + offset_q;
    ex_ale = ((size_q == 2'd1) & addr[0]) | ((size_q == 2'd2) & (addr[1:0] != 2'b00));
    case (size_q)
      2'd0: begin
        wstrb = 4'b0001 << addr[1:0];
        wdata = {4{st_data_q[7:0]}};
      end
      2'd1: begin
        wstrb = 4'b0011 << {addr[1], 1'b0};
        wdata = {2{st_data_q[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = st_data_q;
      end
    endcase
  end

  // Memory op that would go to the bus unless the orphan counter is still draining
  assign issue_needed = (mem_re_q | mem_we_q) & ~ex_ale & ~exc_q & ~MEM_exception &
                        ~WB_exception;
  assign issue_ok     = exe_valid_q & issue_needed & (cnt_q == 2'd0);

  // Request FSM: next state, req, handoff permission and accepted-request tag
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    go       = 1'b0;
    mem_req  = 1'b0;
    inflight = 1'b0;
    unique case (state_q)
      StIdle: begin
        req      = issue_ok;
        go       = ~issue_needed | (req & data_sram_addr_ok);
        mem_req  = req & data_sram_addr_ok;
        inflight = req & data_sram_addr_ok;
        if (req & ~data_sram_addr_ok) begin
          state_d = StWait;
        end else if (req & data_sram_addr_ok & ~MEM_allow) begin
          state_d = StDone;
        end
      end
      StWait: begin
        req      = 1'b1;
        go       = data_sram_addr_ok;
        mem_req  = data_sram_addr_ok;
        inflight = 1'b1;
        // A flush racing the accept leaves nothing to hand off, so go straight to idle
        if (data_sram_addr_ok) begin
          state_d = (MEM_allow | WB_exception) ? StIdle : StDone;
        end else if (WB_exception) begin
          state_d = StDrain;
        end
      end
      StDone: begin
        go       = 1'b1;
        mem_req  = 1'b1;
        inflight = 1'b1;
        if (MEM_allow | WB_exception) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        // Flushed instruction's req must still complete its handshake
        req = 1'b1;
        if (data_sram_addr_ok) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Orphaned-response counter: add flushed outstanding requests, drop one per data_ok
  always_comb begin
    cnt_d = cnt_q;
    if (WB_exception) begin
      cnt_d = cnt_d + {1'b0, MEM_wait_data} + {1'b0, inflight};
    end
    if (data_sram_data_ok & (cnt_q != 2'd0)) begin
      cnt_d = cnt_d - 2'd1;
    end
  end

  // FSM state and orphan counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign EXE_allow        = ~reset & (state_q != StDrain) & (~exe_valid_q | (go & MEM_allow));
  assign EXE_to_MEM_valid = exe_valid_q & go;
  assign EXE_to_MEM_bus   = {payload_q, addr, ex_ale, mem_req};
  assign data_sram_req    = req;
  assign data_sram_wr     = mem_we_q;
  assign data_sram_size   = size_q;
  assign data_sram_wstrb  = mem_we_q ? wstrb : 4'b0000;
  assign data_sram_addr   = addr;
  assign data_sram_wdata  = wdata;
  assign data_ok_mask     = (cnt_q != 2'd0);

endmodule

// File: tb/tb_exe_mem_issue.sv
// Bench for exe_mem_issue: table vectors, flush/backpressure/reset sequences and
// randomized traffic against a transaction-level reference model.
module tb_exe_mem_issue;
  localparam int unsigned PW = 150;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            ID_to_EXE_valid, EXE_allow;
  logic [PW-1:0]   id_payload;
  logic [31:0]     id_base, id_offset, id_st_data;
  logic            id_mem_re, id_mem_we, id_exception;
  logic [1:0]      id_mem_size;
  logic            MEM_allow, MEM_exception, WB_exception, MEM_wait_data;
  logic            EXE_to_MEM_valid;
  logic [PW+33:0]  EXE_to_MEM_bus;
  logic            data_sram_req, data_sram_wr;
  logic [1:0]      data_sram_size;
  logic [3:0]      data_sram_wstrb;
  logic [31:0]     data_sram_addr, data_sram_wdata;
  logic            data_sram_addr_ok, data_sram_data_ok, data_ok_mask;

  exe_mem_issue #(.PAY_W(PW)) dut (
    .clk               (clk),
    .reset             (reset),
    .ID_to_EXE_valid   (ID_to_EXE_valid),
    .EXE_allow         (EXE_allow),
    .id_payload        (id_payload),
    .id_base           (id_base),
    .id_offset         (id_offset),
    .id_st_data        (id_st_data),
    .id_mem_re         (id_mem_re),
    .id_mem_we         (id_mem_we),
    .id_mem_size       (id_mem_size),
    .id_exception      (id_exception),
    .MEM_allow         (MEM_allow),
    .MEM_exception     (MEM_exception),
    .WB_exception      (WB_exception),
    .MEM_wait_data     (MEM_wait_data),
    .EXE_to_MEM_valid  (EXE_to_MEM_valid),
    .EXE_to_MEM_bus    (EXE_to_MEM_bus),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_ok_mask      (data_ok_mask)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, 256'(act), 256'(exp));
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, 256'(act), 256'(exp));
  endtask

  // Reference model: instruction held in EXE, whether its request is raised but not
  // yet accepted, whether it was accepted and awaits handoff, and orphan count.
  bit            m_valid, m_raised, m_accepted;
  int            m_orph;
  logic [PW-1:0] m_pay;
  logic [31:0]   m_base, m_off, m_data;
  logic          m_re, m_we, m_exc;
  logic [1:0]    m_size;

  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  bit          e_ale, e_req, e_acc, e_go, e_tomem, e_allow, e_mreq, e_mask;

  task automatic reset_model();
    m_valid = 1'b0; m_raised = 1'b0; m_accepted = 1'b0; m_orph = 0;
    m_pay = '0; m_base = '0; m_off = '0; m_data = '0;
    m_re = 1'b0; m_we = 1'b0; m_exc = 1'b0; m_size = 2'd0;
  endtask

  task automatic model_eval();
    int  n, lane;
    bit  eligible;
    e_addr = m_base + m_off;
    e_ale  = (m_size == 2'd1 && e_addr[0]) || (m_size == 2'd2 && e_addr[1:0] != 2'b00);
    n      = (m_size == 2'd0) ? 1 : (m_size == 2'd1) ? 2 : 4;
    lane   = int'(e_addr[1:0]) & ~(n - 1);
    e_wstrb = 4'b0000;
    e_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (m_we && i >= lane && i < lane + n) e_wstrb[i] = 1'b1;
      e_wdata[8*i +: 8] = m_data[8*(i % n) +: 8];
    end
    eligible = (m_re || m_we) && !e_ale && !m_exc && !MEM_exception && !WB_exception;
    e_req    = m_raised || (m_valid && !m_accepted && eligible && m_orph == 0);
    e_acc    = e_req && data_sram_addr_ok;
    e_go     = m_accepted ? 1'b1 : m_raised ? data_sram_addr_ok : (!eligible || e_acc);
    e_tomem  = m_valid && e_go;
    e_allow  = !(m_raised && !m_valid) && (!m_valid || (e_go && MEM_allow));
    e_mreq   = m_accepted || e_acc;
    e_mask   = (m_orph != 0);
  endtask

  task automatic model_step();
    bit inflight, raised_n, accepted_n;
    inflight = m_valid && (m_raised || m_accepted || e_acc);
    if (WB_exception) m_orph += int'(MEM_wait_data) + int'(inflight);
    if (data_sram_data_ok && e_mask) m_orph--;
    if (e_acc) begin
      raised_n   = 1'b0;
      accepted_n = m_valid && !WB_exception && !MEM_allow;
    end else if (e_req) begin
      raised_n   = 1'b1;
      accepted_n = 1'b0;
    end else begin
      raised_n   = 1'b0;
      accepted_n = m_accepted && !MEM_allow && !WB_exception;
    end
    m_raised   = raised_n;
    m_accepted = accepted_n;
    if (ID_to_EXE_valid && e_allow) begin
      m_pay = id_payload; m_base = id_base; m_off = id_offset; m_data = id_st_data;
      m_re = id_mem_re; m_we = id_mem_we; m_size = id_mem_size; m_exc = id_exception;
    end
    m_valid = WB_exception ? 1'b0 : (e_allow ? bit'(ID_to_EXE_valid) : m_valid);
  endtask

  task automatic compare_all();
    chk1("EXE_allow", EXE_allow, e_allow);
    chk1("EXE_to_MEM_valid", EXE_to_MEM_valid, e_tomem);
    chk1("data_sram_req", data_sram_req, e_req);
    chk1("data_ok_mask", data_ok_mask, e_mask);
    if (e_req) begin
      chk32("data_sram_addr", data_sram_addr, e_addr);
      chk1("data_sram_wr", data_sram_wr, m_we);
      chk32("data_sram_size", 32'(data_sram_size), 32'(m_size));
      chk32("data_sram_wstrb", 32'(data_sram_wstrb), 32'(e_wstrb));
      chk32("data_sram_wdata", data_sram_wdata, e_wdata);
    end
    if (e_tomem) check("EXE_to_MEM_bus", 256'(EXE_to_MEM_bus),
                       256'({m_pay, e_addr, e_ale, e_mreq}));
  endtask

  // One clock: settle, compare against the model, advance the model, cross the edge
  task automatic cycle();
    #1;
    model_eval();
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_instr(input logic v, input logic [31:0] b, input logic [31:0] o,
                             input logic [31:0] d, input logic re, input logic we,
                             input logic [1:0] sz, input logic exc);
    logic [159:0] pw;
    for (int i = 0; i < 5; i++) pw[32*i +: 32] = $urandom;
    ID_to_EXE_valid = v; id_payload = pw[PW-1:0];
    id_base = b; id_offset = o; id_st_data = d;
    id_mem_re = re; id_mem_we = we; id_mem_size = sz; id_exception = exc;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk1({tag, ".allow"}, EXE_allow, 1'b0);
    chk1({tag, ".tomem"}, EXE_to_MEM_valid, 1'b0);
    chk1({tag, ".req"}, data_sram_req, 1'b0);
    chk1({tag, ".wr"}, data_sram_wr, 1'b0);
    chk1({tag, ".mask"}, data_ok_mask, 1'b0);
    chk32({tag, ".size"}, 32'(data_sram_size), 32'h0);
    chk32({tag, ".wstrb"}, 32'(data_sram_wstrb), 32'h0);
    chk32({tag, ".addr"}, data_sram_addr, 32'h0);
    chk32({tag, ".wdata"}, data_sram_wdata, 32'h0);
    check({tag, ".bus"}, 256'(EXE_to_MEM_bus), 256'h0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] base, off, data;
    logic        re, we;
    logic [1:0]  size;
    logic        x_req;
    logic [31:0] x_addr;
    logic [3:0]  x_wstrb;
    logic [31:0] x_wdata;
    logic        x_ale, x_mreq;
  } vec_t;

  // Flush during a stalled request, then drain the orphans ahead of a queued load
  task automatic flush_seq(input logic mwd, input logic [31:0] qbase);
    int beats = 1 + int'(mwd);
    drive_instr(1'b1, 32'h4000, 32'h10, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    MEM_allow = 1'b1;
    cycle();
    ID_to_EXE_valid = 1'b0;
    settle(); chk1("fl.req_c1", data_sram_req, 1'b1); chk32("fl.addr_c1", data_sram_addr, 32'h4010);
    cycle();
    WB_exception = 1'b1; MEM_wait_data = mwd;
    settle(); chk1("fl.req_c2", data_sram_req, 1'b1);
    cycle();
    WB_exception = 1'b0; MEM_wait_data = 1'b0;
    settle();
    chk1("fl.req_drain", data_sram_req, 1'b1);
    chk32("fl.addr_drain", data_sram_addr, 32'h4010);
    chk1("fl.allow_drain", EXE_allow, 1'b0);
    chk1("fl.mask_drain", data_ok_mask, 1'b1);
    cycle();
    data_sram_addr_ok = 1'b1;
    settle(); chk1("fl.req_aok", data_sram_req, 1'b1); chk1("fl.allow_aok", EXE_allow, 1'b0);
    cycle();
    data_sram_addr_ok = 1'b0;
    settle(); chk1("fl.allow_idle", EXE_allow, 1'b1); chk1("fl.mask_idle", data_ok_mask, 1'b1);
    drive_instr(1'b1, qbase, 32'h0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    cycle();
    ID_to_EXE_valid = 1'b0;
    for (int k = 0; k < beats; k++) begin
      data_sram_data_ok = 1'b1;
      settle(); chk1("fl.mask_beat", data_ok_mask, 1'b1); chk1("fl.req_blocked", data_sram_req, 1'b0);
      cycle();
    end
    data_sram_data_ok = 1'b0;
    settle();
    chk1("fl.mask_clear", data_ok_mask, 1'b0);
    chk1("fl.req_queued", data_sram_req, 1'b1);
    chk32("fl.addr_queued", data_sram_addr, qbase);
    data_sram_addr_ok = 1'b1;
    cycle();
    data_sram_addr_ok = 1'b0;
  endtask

  initial begin
    vec_t vecs[$];
    reset = 1'b1;
    drive_instr(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    MEM_allow = 1'b0; MEM_exception = 1'b0; WB_exception = 1'b0; MEM_wait_data = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;
    settle(); chk1("reset.allow_after", EXE_allow, 1'b1);

    vecs.push_back('{"ld_word", 32'h1000, 32'h4, 32'h0, 1'b1, 1'b0, 2'd2,
                     1'b1, 32'h1004, 4'b0000, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{"st_byte", 32'h1000, 32'h3, 32'hAB, 1'b0, 1'b1, 2'd0,
                     1'b1, 32'h1003, 4'b1000, 32'hABABABAB, 1'b0, 1'b1});
    vecs.push_back('{"ld_half_ale", 32'h2000, 32'h1, 32'h0, 1'b1, 1'b0, 2'd1,
                     1'b0, 32'h2001, 4'b0000, 32'h0, 1'b1, 1'b0});
    vecs.push_back('{"st_half_hi", 32'h2000, 32'h2, 32'h1234, 1'b0, 1'b1, 2'd1,
                     1'b1, 32'h2002, 4'b1100, 32'h12341234, 1'b0, 1'b1});
    vecs.push_back('{"st_word", 32'h3000, 32'h8, 32'hDEADBEEF, 1'b0, 1'b1, 2'd2,
                     1'b1, 32'h3008, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b1});
    vecs.push_back('{"st_byte1", 32'h3000, 32'h1, 32'h5A, 1'b0, 1'b1, 2'd0,
                     1'b1, 32'h3001, 4'b0010, 32'h5A5A5A5A, 1'b0, 1'b1});
    vecs.push_back('{"ld_word_ale", 32'h10, 32'h2, 32'h0, 1'b1, 1'b0, 2'd2,
                     1'b0, 32'h12, 4'b0000, 32'h0, 1'b1, 1'b0});
    vecs.push_back('{"ld_wrap", 32'hFFFFFFFC, 32'h8, 32'h0, 1'b1, 1'b0, 2'd2,
                     1'b1, 32'h4, 4'b0000, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{"non_mem", 32'h5000, 32'h1, 32'h0, 1'b0, 1'b0, 2'd0,
                     1'b0, 32'h5001, 4'b0000, 32'h0, 1'b0, 1'b0});

    MEM_allow = 1'b1;
    foreach (vecs[i]) begin
      drive_instr(1'b1, vecs[i].base, vecs[i].off, vecs[i].data, vecs[i].re, vecs[i].we,
                  vecs[i].size, 1'b0);
      cycle();
      ID_to_EXE_valid = 1'b0;
      data_sram_addr_ok = 1'b1;
      settle();
      chk1({vecs[i].name, ".req"}, data_sram_req, vecs[i].x_req);
      chk32({vecs[i].name, ".addr"}, data_sram_addr, vecs[i].x_addr);
      chk32({vecs[i].name, ".wstrb"}, 32'(data_sram_wstrb), 32'(vecs[i].x_wstrb));
      chk32({vecs[i].name, ".wdata"}, data_sram_wdata, vecs[i].x_wdata);
      chk1({vecs[i].name, ".wr"}, data_sram_wr, vecs[i].we);
      chk1({vecs[i].name, ".tomem"}, EXE_to_MEM_valid, 1'b1);
      chk1({vecs[i].name, ".ale"}, EXE_to_MEM_bus[1], vecs[i].x_ale);
      chk1({vecs[i].name, ".mreq"}, EXE_to_MEM_bus[0], vecs[i].x_mreq);
      cycle();
      data_sram_addr_ok = 1'b0;
    end

    flush_seq(1'b0, 32'h8000);
    flush_seq(1'b1, 32'h8100);

    // Accepted request held in EXE by backpressure: no second request
    drive_instr(1'b1, 32'h6000, 32'h0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    MEM_allow = 1'b1;
    cycle();
    ID_to_EXE_valid = 1'b0;
    data_sram_addr_ok = 1'b1; MEM_allow = 1'b0;
    settle(); chk1("bp.req_accept", data_sram_req, 1'b1);
    cycle();
    data_sram_addr_ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk1("bp.req_low", data_sram_req, 1'b0);
      chk1("bp.tomem", EXE_to_MEM_valid, 1'b1);
      chk1("bp.mreq", EXE_to_MEM_bus[0], 1'b1);
      chk1("bp.allow", EXE_allow, 1'b0);
      cycle();
    end
    MEM_allow = 1'b1;
    settle(); chk1("bp.allow_release", EXE_allow, 1'b1);
    cycle();
    settle(); chk1("bp.empty", EXE_to_MEM_valid, 1'b0); chk1("bp.req_empty", data_sram_req, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int op;
      op = int'($urandom_range(0, 2));
      drive_instr(1'($urandom_range(0, 9) < 7), $urandom, 32'($urandom_range(0, 15)), $urandom,
                  1'(op == 1), 1'(op == 2), 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 9) == 0));
      MEM_allow         = ($urandom_range(0, 9) < 7);
      MEM_exception     = ($urandom_range(0, 9) == 0);
      WB_exception      = (m_orph == 0) && ($urandom_range(0, 19) == 0);
      MEM_wait_data     = 1'($urandom_range(0, 1));
      data_sram_data_ok = ($urandom_range(0, 9) < 3);
      data_sram_addr_ok = 1'b0;
      model_eval();
      data_sram_addr_ok = e_req ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle();
    end

    // Asynchronous reset while a request is outstanding
    MEM_exception = 1'b0; WB_exception = 1'b0; MEM_wait_data = 1'b0;
    data_sram_data_ok = 1'b0; data_sram_addr_ok = 1'b0; MEM_allow = 1'b1;
    repeat (4) cycle();
    drive_instr(1'b1, 32'h7000, 32'h4, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    cycle();
    ID_to_EXE_valid = 1'b0;
    cycle();
    settle(); chk1("arst.req_before", data_sram_req, 1'b1);
    reset = 1'b1;
    #1;
    check_zero_outputs("arst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
